// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-requester memory arbiter.
//   state_e   : arbiter FSM states
//   side_e    : which requester was granted most recently
//   mem_req_t : request captured at grant time and replayed on the memory port
package mem_arbiter_types;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } state_e;

    typedef enum logic {
        SIDE_I = 1'b0,
        SIDE_D = 1'b1
    } side_e;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

    localparam logic [3:0] BE_NONE = 4'b0000;
    localparam logic [3:0] BE_ALL  = 4'b1111;

endpackage

// File: rtl/mem_watchdog.sv
// Wait counter for an outstanding memory access plus a sticky timeout flag.
//   clk, rst_n : clock, synchronous active-low reset
//   clr_i      : restart the count (new grant)
//   active_i   : an access is outstanding this cycle
//   resp_i     : memory responded this cycle
//   timeout_o  : sticky, set once the count reaches TIMEOUT_CYCLES
module mem_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic active_i,
    input  logic resp_i,
    output logic timeout_o
);

    localparam int unsigned   CW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout_q, timeout_d;

    // Counter stops at LIMIT so it never wraps while the FSM keeps waiting.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (active_i && !resp_i && (cnt_q != LIMIT))
            cnt_d = cnt_q + 1'b1;
        timeout_d = timeout_q | (cnt_d == LIMIT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates an instruction port and a data port onto one memory port.
//   clk, rst_n        : clock, synchronous active-low reset
//   inst_*            : instruction read requester (held until inst_resp)
//   data_*            : data read/write requester (held until data_resp)
//   mem_*             : shared memory port; request fields are registered
//   proto_err         : sticky, data_read and data_write seen together
//   timeout           : sticky, an access waited TIMEOUT_CYCLES without mem_resp
module mem_arbiter
    import mem_arbiter_types::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inst_read,
    input  logic [31:0] inst_address,
    output logic        inst_resp,
    output logic [31:0] inst_rdata,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [3:0]  data_byte_enable,
    input  logic [31:0] data_address,
    input  logic [31:0] data_wdata,
    output logic        data_resp,
    output logic [31:0] data_rdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [3:0]  mem_byte_enable,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    input  logic        mem_resp,
    input  logic [31:0] mem_rdata,
    output logic        proto_err,
    output logic        timeout
);

    state_e   state_q, state_d;
    side_e    last_q, last_d;
    mem_req_t req_q, req_d;
    logic     perr_q, perr_d;
    logic     grant;
    logic     data_want;

    assign data_want = data_read | data_write;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        req_d   = req_q;
        perr_d  = perr_q;
        grant   = 1'b0;
        case (state_q)
            IDLE: begin
                if (data_read && data_write)
                    perr_d = 1'b1;
                // On a tie, serve whichever side was not served last.
                if (inst_read && (!data_want || last_q == SIDE_D)) begin
                    grant   = 1'b1;
                    state_d = GRANT_I;
                    last_d  = SIDE_I;
                    req_d   = '{rd: 1'b1, wr: 1'b0, be: BE_ALL,
                                addr: inst_address, wdata: 32'h0};
                end else if (data_want) begin
                    grant   = 1'b1;
                    state_d = GRANT_D;
                    last_d  = SIDE_D;
                    // An illegal read+write is carried out as a write.
                    req_d   = '{rd: !data_write, wr: data_write,
                                be: data_byte_enable,
                                addr: data_address, wdata: data_wdata};
                end
            end
            GRANT_I, GRANT_D: begin
                // Back to IDLE always costs one cycle so requesters can drop.
                if (mem_resp) begin
                    state_d  = IDLE;
                    req_d.rd = 1'b0;
                    req_d.wr = 1'b0;
                    req_d.be = BE_NONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= SIDE_I;
            req_q   <= '0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            req_q   <= req_d;
            perr_q  <= perr_d;
        end
    end

    mem_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (grant),
        .active_i (state_q != IDLE),
        .resp_i   (mem_resp),
        .timeout_o(timeout)
    );

    assign mem_read        = req_q.rd;
    assign mem_write       = req_q.wr;
    assign mem_byte_enable = req_q.be;
    assign mem_address     = req_q.addr;
    assign mem_wdata       = req_q.wdata;

    assign inst_resp  = mem_resp & (state_q == GRANT_I);
    assign data_resp  = mem_resp & (state_q == GRANT_D);
    assign inst_rdata = mem_rdata;
    assign data_rdata = mem_rdata;
    assign proto_err  = perr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        inst_read;
    logic [31:0] inst_address;
    logic        inst_resp;
    logic [31:0] inst_rdata;
    logic        data_read, data_write;
    logic [3:0]  data_byte_enable;
    logic [31:0] data_address, data_wdata;
    logic        data_resp;
    logic [31:0] data_rdata;
    logic        mem_read, mem_write;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_address, mem_wdata;
    logic        mem_resp;
    logic [31:0] mem_rdata;
    logic        proto_err, timeout;

    int checks   = 0;
    int failures = 0;

    mem_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .inst_read(inst_read), .inst_address(inst_address),
        .inst_resp(inst_resp), .inst_rdata(inst_rdata),
        .data_read(data_read), .data_write(data_write),
        .data_byte_enable(data_byte_enable),
        .data_address(data_address), .data_wdata(data_wdata),
        .data_resp(data_resp), .data_rdata(data_rdata),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_byte_enable(mem_byte_enable),
        .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_resp(mem_resp), .mem_rdata(mem_rdata),
        .proto_err(proto_err), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; inst_read = 1'b0; inst_address = 32'h0;
        data_read = 1'b0; data_write = 1'b0; data_byte_enable = 4'h0;
        data_address = 32'h0; data_wdata = 32'h0;
        mem_resp = 1'b0; mem_rdata = 32'h0;

        // Reset state
        tick(); tick();
        chk1("rst_mem_read", mem_read, 1'b0);
        chk1("rst_mem_write", mem_write, 1'b0);
        chk4("rst_be", mem_byte_enable, 4'h0);
        chk1("rst_proto_err", proto_err, 1'b0);
        chk1("rst_timeout", timeout, 1'b0);
        rst_n = 1'b1;
        tick();

        // Single instruction read, memory answers in cycle 4
        inst_read = 1'b1; inst_address = 32'h0000_0060;
        tick();
        chk1("i1_c1_read", mem_read, 1'b1);
        chk1("i1_c1_write", mem_write, 1'b0);
        chk4("i1_c1_be", mem_byte_enable, 4'hF);
        chk32("i1_c1_addr", mem_address, 32'h0000_0060);
        chk1("i1_c1_noresp", inst_resp, 1'b0);
        tick();
        chk1("i1_c2_read", mem_read, 1'b1);
        tick();
        chk1("i1_c3_read", mem_read, 1'b1);
        tick();
        mem_resp = 1'b1; mem_rdata = 32'h0000_0013;
        #1;
        chk1("i1_c4_resp", inst_resp, 1'b1);
        chk32("i1_c4_rdata", inst_rdata, 32'h0000_0013);
        chk1("i1_c4_no_dresp", data_resp, 1'b0);
        inst_read = 1'b0;
        tick();
        mem_resp = 1'b0;
        chk1("i1_c5_idle_read", mem_read, 1'b0);
        chk4("i1_c5_idle_be", mem_byte_enable, 4'h0);
        // Stray mem_resp in IDLE
        mem_resp = 1'b1;
        #1;
        chk1("idle_resp_i", inst_resp, 1'b0);
        chk1("idle_resp_d", data_resp, 1'b0);
        mem_resp = 1'b0;

        // Simultaneous requests from reset: data first
        do_reset();
        inst_read = 1'b1; inst_address = 32'h0000_0060;
        data_write = 1'b1; data_address = 32'h0000_0100;
        data_wdata = 32'hDEAD_BEEF; data_byte_enable = 4'b0011;
        tick();
        chk1("tie_d_write", mem_write, 1'b1);
        chk1("tie_d_read", mem_read, 1'b0);
        chk4("tie_d_be", mem_byte_enable, 4'b0011);
        chk32("tie_d_addr", mem_address, 32'h0000_0100);
        chk32("tie_d_wdata", mem_wdata, 32'hDEAD_BEEF);
        mem_resp = 1'b1;
        #1;
        chk1("tie_d_resp", data_resp, 1'b1);
        chk1("tie_d_no_iresp", inst_resp, 1'b0);
        data_write = 1'b0;
        tick();
        mem_resp = 1'b0;
        chk1("tie_gap_read", mem_read, 1'b0);
        chk1("tie_gap_write", mem_write, 1'b0);
        tick();
        chk1("tie_i_read", mem_read, 1'b1);
        chk32("tie_i_addr", mem_address, 32'h0000_0060);
        chk4("tie_i_be", mem_byte_enable, 4'hF);
        mem_resp = 1'b1;
        #1;
        chk1("tie_i_resp", inst_resp, 1'b1);
        inst_read = 1'b0;
        tick();
        mem_resp = 1'b0;

        // Continuous contention: D,I,D,I,D,I (last grant was inst)
        inst_read = 1'b1; data_write = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk1($sformatf("rr%0d_write", k), mem_write, (k % 2) == 0);
            chk1($sformatf("rr%0d_read", k), mem_read, (k % 2) == 1);
            chk32($sformatf("rr%0d_addr", k), mem_address,
                  ((k % 2) == 0) ? 32'h0000_0100 : 32'h0000_0060);
            mem_resp = 1'b1;
            if (k == 5) begin
                inst_read = 1'b0; data_write = 1'b0;
            end
            tick();
            mem_resp = 1'b0;
        end

        // Read and write together: flagged, carried out as a write
        data_read = 1'b1; data_write = 1'b1;
        data_address = 32'h0000_0200; data_wdata = 32'h1234_5678;
        data_byte_enable = 4'b1100;
        #1;
        chk1("perr_before", proto_err, 1'b0);
        tick();
        chk1("perr_set", proto_err, 1'b1);
        chk1("perr_write", mem_write, 1'b1);
        chk1("perr_read", mem_read, 1'b0);
        chk4("perr_be", mem_byte_enable, 4'b1100);
        mem_resp = 1'b1;
        data_read = 1'b0; data_write = 1'b0;
        tick();
        mem_resp = 1'b0;
        tick();
        chk1("perr_sticky", proto_err, 1'b1);

        // Withheld response: timeout after 8 grant cycles
        inst_read = 1'b1; inst_address = 32'h0000_0080;
        tick();
        for (int k = 0; k < 7; k++) tick();
        chk1("to_c8_clear", timeout, 1'b0);
        chk1("to_c8_read", mem_read, 1'b1);
        tick();
        chk1("to_c9_set", timeout, 1'b1);
        chk1("to_c9_read", mem_read, 1'b1);
        tick(); tick(); tick();
        chk1("to_wait_read", mem_read, 1'b1);
        chk32("to_wait_addr", mem_address, 32'h0000_0080);
        mem_resp = 1'b1; mem_rdata = 32'hCAFE_0001;
        #1;
        chk1("to_late_resp", inst_resp, 1'b1);
        chk32("to_late_rdata", inst_rdata, 32'hCAFE_0001);
        inst_read = 1'b0;
        tick();
        mem_resp = 1'b0;
        chk1("to_done_read", mem_read, 1'b0);
        chk1("to_sticky", timeout, 1'b1);

        // Reset during a data write abandons it
        data_write = 1'b1; data_address = 32'h0000_0300;
        data_wdata = 32'h0BAD_F00D; data_byte_enable = 4'hF;
        tick();
        chk1("rm_write", mem_write, 1'b1);
        rst_n = 1'b0;
        tick();
        chk1("rm_write_off", mem_write, 1'b0);
        chk1("rm_read_off", mem_read, 1'b0);
        chk1("rm_no_dresp", data_resp, 1'b0);
        chk1("rm_perr_clr", proto_err, 1'b0);
        chk1("rm_to_clr", timeout, 1'b0);
        mem_resp = 1'b1;
        #1;
        chk1("rm_resp_ignored", data_resp, 1'b0);
        mem_resp = 1'b0; data_write = 1'b0;
        rst_n = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 256, meaning cycles a granted access may wait for mem_resp before timeout is flagged.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port inst_read  input  1  instruction-side read request, held until inst_resp.
REQ-005 SHALL have port inst_address  input  32  instruction fetch address.
REQ-006 SHALL have port inst_resp  output  1  instruction access complete.
REQ-007 SHALL have port inst_rdata  output  32  instruction read data, valid with inst_resp.
REQ-008 SHALL have port data_read / data_write  input  1 each  data-side requests, held until data_resp.
REQ-009 SHALL have port data_byte_enable  input  4  write byte mask.
REQ-010 SHALL have port data_address / data_wdata  input  32 each  data address and write data.
REQ-011 SHALL have port data_resp  output  1  data access complete; data_rdata  output  32  read data, valid with data_resp.
REQ-012 SHALL have ports mem_read, mem_write  output  1; mem_byte_enable  output  4; mem_address, mem_wdata  output  32; mem_resp  input  1; mem_rdata  input  32  shared memory port.
REQ-013 SHALL have port proto_err  output  1  sticky: data_read and data_write both high when sampled.
REQ-014 SHALL have port timeout  output  1  sticky: granted access exceeded TIMEOUT_CYCLES.

Function
REQ-015 SHALL implement FSM states IDLE, GRANT_I, GRANT_D.
REQ-016 In IDLE, requests SHALL be sampled; a grant transitions on the next edge; mem_* outputs are driven from registers captured at that edge (1-cycle request-to-memory latency).
REQ-017 Only-inst request in IDLE -> GRANT_I; only-data request -> GRANT_D; none -> stay IDLE.
REQ-018 Both requesting in IDLE -> round-robin: grant the side not served last; the last_grant register resets to inst (data wins first tie).
REQ-019 On grant, address, wdata, byte_enable and read/write type SHALL be captured into registers; mem_* remain stable until mem_resp.
REQ-020 In IDLE, mem_read, mem_write SHALL be 0, and mem_byte_enable SHALL be 4'b0000.
REQ-021 GRANT_I SHALL drive mem_read=1, mem_write=0; mem_byte_enable SHALL be 4'b1111.
REQ-022 GRANT_D SHALL drive mem_read or mem_write per captured type and the captured byte_enable.
REQ-023 inst_resp SHALL equal mem_resp & (state==GRANT_I); data_resp SHALL equal mem_resp & (state==GRANT_D); resp is combinational, same cycle.
REQ-024 inst_rdata and data_rdata SHALL pass mem_rdata through combinationally.
REQ-025 On mem_resp in a grant state -> IDLE; one mandatory IDLE cycle SHALL separate consecutive grants so requesters can drop requests.
REQ-026 mem_resp while in IDLE SHALL be ignored; no resp output asserts.
REQ-027 data_read & data_write sampled in IDLE SHALL set proto_err, and SHALL be granted as a write.
REQ-028 A wait counter SHALL clear on grant and increment each grant-state cycle without mem_resp; reaching TIMEOUT_CYCLES sets timeout; the counter saturates; the FSM keeps waiting.

Reset
REQ-029 rst_n low at a clock edge SHALL force IDLE, set last_grant=inst, and clear capture registers, counter, proto_err and timeout.
REQ-030 Reset mid-access SHALL abandon the access; mem_read/mem_write are 0 from the next cycle, and no resp is issued.

Structure
REQ-031 Package mem_arbiter_types SHALL hold the state enum (IDLE, GRANT_I, GRANT_D) and the grant-side enum (SIDE_I, SIDE_D).
REQ-032 Sub-module mem_watchdog (wait counter plus sticky timeout, parameter TIMEOUT_CYCLES) SHALL be the only sub-module.

Verification
REQ-033 Inst read 0x0000_0060, memory resp after 3 cycles with 0x0000_0013 -> mem_read high cycles 1-3, inst_resp with rdata 0x13 cycle 4, IDLE cycle 5.
REQ-034 Simultaneous inst read 0x60 and data write 0x100/0xDEADBEEF/4'b0011 from reset -> data granted first (mem_write, be 0011), then inst after one IDLE cycle.
REQ-035 Both sides request continuously for 6 accesses -> grants alternate D,I,D,I,D,I.
REQ-036 data_read and data_write both high -> proto_err=1 sticky, mem_write issued.
REQ-037 TIMEOUT_CYCLES=8, mem_resp withheld -> timeout asserts after 8 grant cycles, mem_read stays high; late resp still completes.
REQ-038 rst_n low during GRANT_D -> next cycle mem_write=0, no data_resp, flags clear.
